fault_lamp_sequencer: RTL and testbench

//   Upstream feeder for the multi-input/multi-output fault gate. Tracks the

---
 rtl/fault_lamp_if.sv | 29 ++
 rtl/fault_lamp_sequencer.sv | 112 +++++++++++
 tb/tb_fault_lamp_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fault_lamp_if.sv
// Bundles the toggle/hit stimulus and the replayed gate-side outputs of the fault lamp sequencer.
// The master drives lamp toggles, hits and clear; the slave answers with snapshots and FIFO status.
interface fault_lamp_if #(
    parameter int INPUT_COUNT = 2,
    parameter int DEPTH       = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   toggle_valid;
    logic [INPUT_COUNT-1:0] toggle_mask;
    logic                   fault_hit;
    logic                   clear;
    logic [INPUT_COUNT-1:0] gate_in;
    logic                   gate_fault;
    logic [INPUT_COUNT-1:0] lamp_state;
    logic [CNT_W-1:0]       pending;
    logic                   hit_ready;
    logic                   overflow;

    modport master (
        output toggle_valid, toggle_mask, fault_hit, clear,
        input  gate_in, gate_fault, lamp_state, pending, hit_ready, overflow
    );

    modport slave (
        input  toggle_valid, toggle_mask, fault_hit, clear,
        output gate_in, gate_fault, lamp_state, pending, hit_ready, overflow
    );
endinterface

// File: rtl/fault_lamp_sequencer.sv
// Tracks lamp toggle state, snapshots it on every fault hit into a small FIFO, and replays
// each snapshot to the fault gate as a rate-limited single-cycle pulse.
module fault_lamp_sequencer #(
    parameter int                   INPUT_COUNT = 2,
    parameter int                   DEPTH       = 4,
    parameter int                   ISSUE_GAP   = 1,
    parameter logic [INPUT_COUNT-1:0] INIT_STATE = '0
) (
    input  logic         clk,
    input  logic         logic_reset_n,
    fault_lamp_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [GAP_W-1:0]       gap;
    logic [INPUT_COUNT-1:0] lamps;
    logic [INPUT_COUNT-1:0] gate_in_q;
    logic                   gate_fault_q;
    logic                   overflow_q;
    logic [INPUT_COUNT-1:0] mem [DEPTH];

    logic [INPUT_COUNT-1:0] eff;
    logic [INPUT_COUNT-1:0] snapshot;
    logic                   pop;
    logic                   push;
    logic                   hit_ready;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Snapshot folds in this cycle's toggles so the gate sees the lamps as of the hit.
    always_comb begin
        eff       = bus.toggle_valid ? bus.toggle_mask : '0;
        snapshot  = lamps ^ eff;
        pop       = (count != '0) && (gap == '0);
        hit_ready = (count < CNT_W'(DEPTH)) || pop;
        push      = bus.fault_hit && hit_ready && !bus.clear;
    end

    always_ff @(posedge clk or negedge logic_reset_n) begin
        if (!logic_reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            gap          <= '0;
            lamps        <= INIT_STATE;
            gate_in_q    <= INIT_STATE;
            gate_fault_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            gap          <= '0;
            lamps        <= INIT_STATE;
            gate_in_q    <= INIT_STATE;
            gate_fault_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            lamps <= snapshot;

            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end

            if (pop) begin
                rd_ptr       <= ptr_next(rd_ptr);
                gate_in_q    <= mem[rd_ptr];
                gate_fault_q <= 1'b1;
                gap          <= GAP_W'(ISSUE_GAP);
            end else begin
                gate_fault_q <= 1'b0;
                if (gap != '0) begin
                    gap <= gap - GAP_W'(1);
                end
            end

            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            if (bus.fault_hit && !hit_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= snapshot;
        end
    end

    assign bus.gate_in    = gate_in_q;
    assign bus.gate_fault = gate_fault_q;
    assign bus.lamp_state = lamps;
    assign bus.pending    = count;
    assign bus.hit_ready  = hit_ready;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fault_lamp_sequencer.sv
// Directed bench for fault_lamp_sequencer: one instance with a 1-cycle issue gap, one with a
// 3-cycle gap for the full/overflow and clear scenarios.
module tb_fault_lamp_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    int   max_pend_b = 0;
    int   base;

    always #5 clk = ~clk;

    fault_lamp_if #(.INPUT_COUNT(2), .DEPTH(4)) ifa ();
    fault_lamp_if #(.INPUT_COUNT(2), .DEPTH(4)) ifb ();

    fault_lamp_sequencer #(.INPUT_COUNT(2), .DEPTH(4), .ISSUE_GAP(1), .INIT_STATE(2'b00)) dut_a (
        .clk           (clk),
        .logic_reset_n (rst_n),
        .bus           (ifa.slave)
    );

    fault_lamp_sequencer #(.INPUT_COUNT(2), .DEPTH(4), .ISSUE_GAP(3), .INIT_STATE(2'b00)) dut_b (
        .clk           (clk),
        .logic_reset_n (rst_n),
        .bus           (ifb.slave)
    );

    always @(negedge clk) begin
        if (ifa.gate_fault === 1'b1) pulses_a++;
        if (ifb.gate_fault === 1'b1) pulses_b++;
        if (int'(ifb.pending) > max_pend_b) max_pend_b = int'(ifb.pending);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic tv, input logic [1:0] m, input logic hit, input logic clr);
        ifa.toggle_valid = tv;
        ifa.toggle_mask  = m;
        ifa.fault_hit    = hit;
        ifa.clear        = clr;
    endtask

    task automatic drive_b(input logic tv, input logic [1:0] m, input logic hit, input logic clr);
        ifb.toggle_valid = tv;
        ifb.toggle_mask  = m;
        ifb.fault_hit    = hit;
        ifb.clear        = clr;
    endtask

    initial begin
        drive_a(1'b0, 2'b00, 1'b0, 1'b0);
        drive_b(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: reset state
        check("rst_lamp", ifa.lamp_state, 2'b00);
        check("rst_gate_in", ifa.gate_in, 2'b00);
        check("rst_gate_fault", ifa.gate_fault, 1'b0);
        check("rst_pending", ifa.pending, 0);
        check("rst_hit_ready", ifa.hit_ready, 1'b1);
        check("rst_overflow", ifa.overflow, 1'b0);

        // 2: toggle then hit with its own toggle -> snapshot 11
        drive_a(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        check("t2_lamp_c0", ifa.lamp_state, 2'b01);
        drive_a(1'b1, 2'b10, 1'b1, 1'b0);
        tick();
        check("t2_lamp_c1", ifa.lamp_state, 2'b11);
        check("t2_pend", ifa.pending, 1);
        check("t2_gf_early", ifa.gate_fault, 1'b0);
        drive_a(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t2_gf", ifa.gate_fault, 1'b1);
        check("t2_gate_in", ifa.gate_in, 2'b11);
        check("t2_pend_after", ifa.pending, 0);
        tick();
        check("t2_gf_low", ifa.gate_fault, 1'b0);
        check("t2_gate_in_hold", ifa.gate_in, 2'b11);

        // 3: three back-to-back hits, snapshots 01,10,11 from lamps 11
        drive_a(1'b1, 2'b10, 1'b1, 1'b0);
        tick();
        check("t3_pend_e1", ifa.pending, 1);
        check("t3_gf_e1", ifa.gate_fault, 1'b0);
        drive_a(1'b1, 2'b11, 1'b1, 1'b0);
        tick();
        check("t3_pend_e2", ifa.pending, 1);
        check("t3_gf_e2", ifa.gate_fault, 1'b1);
        check("t3_gi_e2", ifa.gate_in, 2'b01);
        drive_a(1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        check("t3_pend_e3", ifa.pending, 2);
        check("t3_gf_e3", ifa.gate_fault, 1'b0);
        check("t3_gi_e3", ifa.gate_in, 2'b01);
        drive_a(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("t3_pend_e4", ifa.pending, 1);
        check("t3_gf_e4", ifa.gate_fault, 1'b1);
        check("t3_gi_e4", ifa.gate_in, 2'b10);
        tick();
        check("t3_pend_e5", ifa.pending, 1);
        check("t3_gf_e5", ifa.gate_fault, 1'b0);
        tick();
        check("t3_pend_e6", ifa.pending, 0);
        check("t3_gf_e6", ifa.gate_fault, 1'b1);
        check("t3_gi_e6", ifa.gate_in, 2'b11);
        tick();
        check("t3_gf_e7", ifa.gate_fault, 1'b0);
        check("t3_lamp", ifa.lamp_state, 2'b11);

        // 4: gap=3, seven back-to-back hits with toggle 01 each
        base = pulses_b;
        drive_b(1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        check("t4_pend_e1", ifb.pending, 1);
        tick();
        check("t4_pend_e2", ifb.pending, 1);
        check("t4_gi_e2", ifb.gate_in, 2'b01);
        check("t4_gf_e2", ifb.gate_fault, 1'b1);
        tick();
        check("t4_pend_e3", ifb.pending, 2);
        tick();
        check("t4_pend_e4", ifb.pending, 3);
        tick();
        check("t4_pend_e5", ifb.pending, 4);
        check("t4_ready_full_pop", ifb.hit_ready, 1'b1);
        check("t4_ovf_e5", ifb.overflow, 1'b0);
        tick();
        check("t4_pend_e6", ifb.pending, 4);
        check("t4_gi_e6", ifb.gate_in, 2'b00);
        check("t4_gf_e6", ifb.gate_fault, 1'b1);
        check("t4_ready_full", ifb.hit_ready, 1'b0);
        check("t4_ovf_e6", ifb.overflow, 1'b0);
        tick();
        check("t4_pend_e7", ifb.pending, 4);
        check("t4_ovf_e7", ifb.overflow, 1'b1);
        check("t4_lamp", ifb.lamp_state, 2'b01);
        drive_b(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("t4_gi_e10", ifb.gate_in, 2'b01);
        check("t4_gf_e10", ifb.gate_fault, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        check("t4_pulses", pulses_b - base, 6);
        check("t4_pend_drained", ifb.pending, 0);
        check("t4_ovf_sticky", ifb.overflow, 1'b1);
        check("t4_max_pend", max_pend_b, 4);

        // 5: clear with pending=3 and a simultaneous hit
        drive_b(1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        check("t5_ovf_cleared", ifb.overflow, 1'b0);
        drive_b(1'b1, 2'b10, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        check("t5_pend3", ifb.pending, 3);
        drive_b(1'b1, 2'b11, 1'b1, 1'b1);
        tick();
        check("t5_pend", ifb.pending, 0);
        check("t5_ovf", ifb.overflow, 1'b0);
        check("t5_lamp", ifb.lamp_state, 2'b00);
        check("t5_gf", ifb.gate_fault, 1'b0);
        check("t5_gi", ifb.gate_in, 2'b00);
        drive_b(1'b0, 2'b00, 1'b0, 1'b0);
        base = pulses_b;
        for (int i = 0; i < 20; i++) tick();
        check("t5_no_pulses", pulses_b - base, 0);

        // 6: async reset with pending=2 and a pulse in flight
        drive_a(1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        check("t6_pend2", ifa.pending, 2);
        check("t6_gf_before", ifa.gate_fault, 1'b1);
        drive_a(1'b0, 2'b00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_gf_async", ifa.gate_fault, 1'b0);
        check("t6_pend_async", ifa.pending, 0);
        check("t6_lamp_async", ifa.lamp_state, 2'b00);
        tick();
        #2;
        rst_n = 1'b1;
        base = pulses_a;
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_stale", pulses_a - base, 0);
        check("t6_gi", ifa.gate_in, 2'b00);
        check("t6_ready", ifa.hit_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
